// File: rtl/pdm_decimator.sv
// pdm_decimator: boxcar decimator that turns a 1-bit pulse-density stream
// into unsigned PCM samples by counting ones over a 2^C_decim clock window.
module pdm_decimator #(
  parameter int C_bits  = 12,
  parameter int C_decim = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              pdm_in,
  output logic [C_bits-1:0] pcm,
  output logic              pcm_valid,
  output logic              clip
);

  logic               sync_meta;
  logic               s;
  logic [C_decim-1:0] wcnt;
  logic [C_decim:0]   acc;
  logic [C_decim:0]   sum;
  logic [C_decim-1:0] sat;
  logic               window_end;

  // Two-flop synchronizer for the asynchronous pin; runs regardless of en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      s         <= 1'b0;
    end else begin
      sync_meta <= pdm_in;
      s         <= sync_meta;
    end
  end

  // Running window sum including the current sample, saturated to C_decim bits.
  always_comb begin
    sum        = acc + {{C_decim{1'b0}}, s};
    sat        = sum[C_decim] ? {C_decim{1'b1}} : sum[C_decim-1:0];
    window_end = (wcnt == {C_decim{1'b1}});
  end

  // Window counter, accumulator and registered sample outputs; en low wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt      <= '0;
      acc       <= '0;
      pcm       <= '0;
      pcm_valid <= 1'b0;
      clip      <= 1'b0;
    end else if (!en) begin
      wcnt      <= '0;
      acc       <= '0;
      pcm_valid <= 1'b0;
    end else if (window_end) begin
      pcm       <= C_bits'(sat) << (C_bits - C_decim);
      clip      <= (sum == '0) || sum[C_decim];
      pcm_valid <= 1'b1;
      wcnt      <= '0;
      acc       <= '0;
    end else begin
      wcnt      <= wcnt + C_decim'(1);
      acc       <= sum;
      pcm_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: randomized and directed stimulus for two decimator
// configurations (12-bit/256-window and 4-bit/16-window) against a
// window-sum reference model.
module tb_pdm_decimator;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        pdm_in;
  logic [11:0] pcm;
  logic        pcm_valid;
  logic        clip;
  logic [3:0]  pcm_small;
  logic        pcm_valid_small;
  logic        clip_small;

  int checks   = 0;
  int failures = 0;

  // Reference model state, index 0 = default DUT, index 1 = small DUT.
  int  dec_log2 [2] = '{8, 4};
  int  out_bits [2] = '{12, 4};
  int  win_count[2];
  int  win_ones [2];
  int  exp_pcm  [2];
  bit  exp_clip [2];
  bit  exp_valid[2];
  bit  pin_q[$];

  pdm_decimator u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pdm_in    (pdm_in),
    .pcm       (pcm),
    .pcm_valid (pcm_valid),
    .clip      (clip)
  );

  pdm_decimator #(.C_bits(4), .C_decim(4)) u_small (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .pdm_in    (pdm_in),
    .pcm       (pcm_small),
    .pcm_valid (pcm_valid_small),
    .clip      (clip_small)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 2; i++) begin
      win_count[i] = 0;
      win_ones[i]  = 0;
      exp_pcm[i]   = 0;
      exp_clip[i]  = 1'b0;
      exp_valid[i] = 1'b0;
    end
    pin_q = {1'b0, 1'b0};
  endtask

  task automatic checkAll();
    checkOutput("pcm_valid", {31'd0, pcm_valid}, {31'd0, exp_valid[0]});
    checkOutput("pcm",       {20'd0, pcm},       exp_pcm[0]);
    checkOutput("clip",      {31'd0, clip},      {31'd0, exp_clip[0]});
    checkOutput("pcm_valid_small", {31'd0, pcm_valid_small}, {31'd0, exp_valid[1]});
    checkOutput("pcm_small",       {28'd0, pcm_small},       exp_pcm[1]);
    checkOutput("clip_small",      {31'd0, clip_small},      {31'd0, exp_clip[1]});
  endtask

  // Drive one clock of stimulus, advance the model, then check both DUTs.
  task automatic applyStimulus(input bit p, input bit e);
    bit s_used;
    int full, sum, sat;
    pdm_in = p;
    en     = e;
    @(posedge clk);
    s_used = pin_q.pop_front();
    pin_q.push_back(p);
    for (int i = 0; i < 2; i++) begin
      exp_valid[i] = 1'b0;
      full = 1 << dec_log2[i];
      if (e) begin
        win_count[i]++;
        win_ones[i] += int'(s_used);
        if (win_count[i] == full) begin
          sum          = win_ones[i];
          sat          = (sum == full) ? full - 1 : sum;
          exp_pcm[i]   = sat * (1 << (out_bits[i] - dec_log2[i]));
          exp_clip[i]  = (sum == 0) || (sum == full);
          exp_valid[i] = 1'b1;
          win_count[i] = 0;
          win_ones[i]  = 0;
        end
      end else begin
        win_count[i] = 0;
        win_ones[i]  = 0;
      end
    end
    #1;
    checkAll();
  endtask

  // Asynchronous reset between clock edges; outputs must clear with no clock.
  task automatic doReset();
    rst_n = 1'b0;
    #1;
    checkOutput("rst_pcm",         {20'd0, pcm},             32'd0);
    checkOutput("rst_pcm_valid",   {31'd0, pcm_valid},       32'd0);
    checkOutput("rst_clip",        {31'd0, clip},            32'd0);
    checkOutput("rst_pcm_small",   {28'd0, pcm_small},       32'd0);
    checkOutput("rst_clip_small",  {31'd0, clip_small},      32'd0);
    rst_n = 1'b1;
    clearModel();
  endtask

  initial begin
    bit phase_bit;
    int guard;
    rst_n  = 1'b0;
    en     = 1'b0;
    pdm_in = 1'b0;
    clearModel();
    #1;
    doReset();

    // Constant zero from reset release: strobe every 256 clocks, pcm 0, clip 1.
    for (int k = 0; k < 600; k++) applyStimulus(1'b0, 1'b1);

    // Constant one: saturated 0xFF0 with clip once the sync pipe is flushed.
    for (int k = 0; k < 600; k++) applyStimulus(1'b1, 1'b1);

    // Reset mid-window while pcm is nonzero.
    $display("[TB] pcm before mid-run reset = 0x%0h", pcm);
    for (int k = 0; k < 37; k++) applyStimulus(1'b1, 1'b1);
    doReset();

    // Alternating 1,0 then 1,0,0,0.
    for (int k = 0; k < 600; k++) applyStimulus(k[0] == 1'b0, 1'b1);
    for (int k = 0; k < 600; k++) applyStimulus(k[1:0] == 2'b00, 1'b1);

    // Drop en for 10 clocks at window sample #100.
    guard = 0;
    while (win_count[0] != 99 && guard < 400) begin
      applyStimulus(1'($urandom), 1'b1);
      guard++;
    end
    checkOutput("reach_sample_99", win_count[0], 32'd99);
    for (int k = 0; k < 10; k++) applyStimulus(1'($urandom), 1'b0);
    for (int k = 0; k < 300; k++) applyStimulus(1'($urandom), 1'b1);

    // en falling exactly on the window-end edge.
    guard = 0;
    while (win_count[0] != 255 && guard < 400) begin
      applyStimulus(1'b1, 1'b1);
      guard++;
    end
    checkOutput("reach_window_end", win_count[0], 32'd255);
    applyStimulus(1'b1, 1'b0);
    for (int k = 0; k < 300; k++) applyStimulus(1'b1, 1'b1);

    // Random density with occasional en drops.
    for (int k = 0; k < 3000; k++) begin
      phase_bit = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
      applyStimulus(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0, phase_bit);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/pdm_decimator.md
Name: pdm_decimator

Overview:
Audio capture path, the receive-side counterpart of the PCM-to-DAC output chain. It takes a 1-bit pulse-density / PWM stream from an external comparator or sigma-delta modulator on an input pin. It reconstructs unsigned PCM samples by counting ones over a fixed power-of-two window (boxcar decimation). Output samples come with a one-cycle valid strobe and a clip flag, and feed the same 12-bit unsigned PCM format used by the wave generators and DAC.

Parameters:
C_bits, 12, PCM output width in bits.
C_decim, 8, log2 of the decimation window in clocks. Legal range is 1 to C_bits. Window length is 2^C_decim enabled clocks.

Ports:
clk  input  1  system clock; all state is updated on its rising edge
rst_n  input  1  asynchronous active-low reset
en  input  1  capture enable; low holds the output and restarts the window
pdm_in  input  1  asynchronous 1-bit density stream from the pin
pcm  output  C_bits  last completed sample, unsigned
pcm_valid  output  1  one-cycle strobe marking a new pcm value
clip  output  1  last window was all zeros or all ones

Behaviour:
- Reset (rst_n low, asynchronous): sync flops, window counter, accumulator, pcm, pcm_valid and clip all go to 0. Release takes effect on the next clk edge.
- Input sync: pdm_in passes through a 2-flop synchronizer giving s. The synchronizer runs regardless of en. Pin-to-s latency is 2 clocks.
- Counter and accumulator:
  - wcnt is C_decim bits wide.
  - acc is C_decim+1 bits wide, so it can hold 0 to 2^C_decim.
- Each edge with en=1 and wcnt < 2^C_decim-1: wcnt += 1, acc += s.
- Each edge with en=1 and wcnt = 2^C_decim-1 (window end):
  - sum = acc + s, range 0 to 2^C_decim.
  - sat = (sum == 2^C_decim) ? 2^C_decim-1 : sum.
  - pcm <= sat << (C_bits - C_decim), so low bits are zero-filled.
  - clip <= (sum == 0) or (sum == 2^C_decim).
  - pcm_valid <= 1.
  - wcnt <= 0, acc <= 0.
- pcm_valid is 0 on every other edge: it is exactly one cycle wide.
- With en held high, pcm_valid recurs every 2^C_decim clocks with no gaps or jitter.
- Each edge with en=0:
  - wcnt <= 0, acc <= 0, pcm_valid <= 0.
  - pcm and clip hold their last values.
  - A partial window is discarded and never emitted.
- en falling on the window-end edge: en=0 has priority. No sample is emitted and counters clear.
- en rising: the first enabled edge counts as window sample #1. The first pcm_valid is high in the cycle after the 2^C_decim-th enabled edge.
- Arithmetic is unsigned throughout. No wrap is possible because the accumulator has a spare bit and the output saturates.
- Reset mid-window: all state clears immediately. The next window starts from sample #1 at the first enabled edge after release.
- No combinational path from any input to any output; all outputs are registered.

Test Plan:
1. Reset: assert rst_n=0 mid-operation with pcm nonzero. Required: pcm=0, pcm_valid=0 and clip=0 immediately, with no clock needed.
2. Defaults, pdm_in=0, en=1 from reset release. Required: pcm_valid pulses first 256 clocks after en is seen high, then every 256 clocks, exactly 1 cycle wide, with pcm=0x000 and clip=1.
3. pdm_in=1 constant, en=1, check from the 2nd window onward (so sync latency is flushed). Required: pcm=0xFF0 (saturated 255<<4) and clip=1.
4. pdm_in alternating 1,0 each clock. Required: every window gives pcm=0x800 (128<<4) and clip=0. Then switch to pattern 1,0,0,0 and require pcm=0x400 from the first full window after the switch.
5. en dropped for 10 clocks at window sample #100, then restored. Required: no pcm_valid for the aborted window and pcm/clip hold their old values. The next pcm_valid arrives exactly 256 clocks after the first re-enabled edge.
6. en falling on the exact window-end edge. Required: no strobe and pcm unchanged. Also run with C_decim=C_bits=4 and pdm_in=1, requiring pcm=0xF and clip=1.
